div_iterative_core: RTL and testbench
=====================================

DIV_ITERATIVE_CORE -- requirements
Module: div_iterative_core

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits and the shift register at 64 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_DIV  input  1  start strobe; sampled on every rising edge.
REQ-005 data_operandA  input  32  signed dividend; sampled only on the edge that accepts a start.
REQ-006 data_operandB  input  32  signed divisor; sampled only on the edge that accepts a start.
REQ-007 quotientAfterShiftFrom64  output  64  {remainder magnitude[63:32], quotient magnitude[31:0]} for the downstream sign-correction stage.
REQ-008 opA_q  output  32  registered copy of the dividend for the latest accepted start.
REQ-009 opB_q  output  32  registered copy of the divisor for the latest accepted start.
REQ-010 data_resultRDY  output  1  one-cycle pulse marking a valid result.
REQ-011 data_exception  output  1  divide-by-zero flag for the latest accepted start.
REQ-012 busy  output  1  high while iterations are in progress.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 Start acceptance: ctrl_DIV=1 at any edge, in any state, SHALL start a new operation; the new start SHALL override the current one (restart semantics).
REQ-015 On the accepting edge E0 the block SHALL:
- latch opA_q and opB_q;
- compute magA=|A| and magB=|B| as 32-bit unsigned values (two's-complement negate when bit31=1; -2^31 maps to 0x80000000);
- load shift register {32'h0, magA};
- clear the 6-bit iteration counter;
- clear data_exception.
REQ-016 If magB=0 at E0, the block SHALL enter DONE directly, load shift register 64'h0 and set data_exception=1.
REQ-017 Otherwise the block SHALL enter RUN with busy=1.
REQ-018 RUN iteration k (edges E1..E32), restoring division:
- form 33-bit diff = {R[31:0],Q[31]} - {1'b0,magB}, where R is the shift-register high word and Q the low word;
- if diff is non-negative: new R = diff[31:0] and new Q = {Q[30:0],1'b1};
- else: new {R,Q} = {R,Q} << 1 with bit0 = 0.
REQ-019 The counter SHALL increment once per iteration; after E32 the block SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle with data_resultRDY=1 and busy=0, then go to IDLE.
REQ-021 Latency: data_resultRDY SHALL be high in the cycle following E32 (33 edges after E0) for nonzero divisors, and in the cycle following E0 for a zero divisor.
REQ-022 quotientAfterShiftFrom64, opA_q, opB_q and data_exception SHALL hold their values through DONE and IDLE until the next accepted start.
REQ-023 A start accepted in the DONE cycle SHALL begin a new operation; data_resultRDY for the old operation SHALL still be seen in that DONE cycle.
REQ-024 The quotient magnitude SHALL satisfy floor(magA/magB) and the remainder magnitude SHALL equal magA mod magB.

Reset
REQ-025 Reset asserted SHALL immediately force IDLE, clear the counter and drive all outputs to 0, including in the middle of an operation.
REQ-026 After reset deassertion no operation SHALL run until ctrl_DIV is sampled high; the partial result of an interrupted operation SHALL be discarded.

Verification
REQ-027 A=100, B=7, start pulse -> resultRDY one cycle after E32; output 64'h00000002_0000000E; exception=0; busy high for E1..E32.
REQ-028 A=-100 (0xFFFFFF9C), B=7 -> low word 0x0000000E, high word 0x00000002; opA_q=0xFFFFFF9C.
REQ-029 A=0x80000000, B=1 -> low word 0x80000000, high word 0; B=0xFFFFFFFF -> low word 0x80000000.
REQ-030 A=55, B=0 -> resultRDY in the cycle after E0; exception=1; output 64'h0; busy never asserted.
REQ-031 Start 100/7, then ctrl_DIV with 9/2 at E10 -> a single resultRDY 33 edges after the second start; output 64'h00000001_00000004.
REQ-032 Reset asserted at E15 of an operation -> all outputs 0 immediately; no resultRDY until a new start.

Source files
------------

// File: rtl/div_iterative_core.sv
// div_iterative_core
// Iterative 32-bit restoring divider working on operand magnitudes.
// Takes 32 iteration cycles per divide; a divide-by-zero finishes
// immediately with the exception flag set. A start strobe is honoured
// in any state and restarts the unit. Signs are restored downstream
// using the registered operand copies.

module div_iterative_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [63:0] quotientAfterShiftFrom64,
    output logic [31:0] opA_q,
    output logic [31:0] opB_q,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] mag_b;
    logic [63:0] shift_q;

    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic [32:0] diff;

    assign quotientAfterShiftFrom64 = shift_q;

    // Operand magnitudes and the trial subtraction for one restoring step
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        mag_a_in = data_operandA;
        mag_b_in = data_operandB;
        if (data_operandA[31]) begin
            mag_a_in = ~data_operandA + 32'd1;
        end
        if (data_operandB[31]) begin
            mag_b_in = ~data_operandB + 32'd1;
        end
        // {R, Q[31]} is exactly shift_q[63:31]
        diff = shift_q[63:31] - {1'b0, mag_b};
    end

    // Control FSM, datapath and registered outputs in one sequential process
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values present before the edge.
        if (reset) begin
            state          <= IDLE;
            count          <= 6'd0;
            mag_b          <= 32'd0;
            shift_q        <= 64'd0;
            opA_q          <= 32'd0;
            opB_q          <= 32'd0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_DIV) begin
            // A start wins over whatever is in progress
            opA_q          <= data_operandA;
            opB_q          <= data_operandB;
            mag_b          <= mag_b_in;
            count          <= 6'd0;
            data_exception <= 1'b0;
            if (mag_b_in == 32'd0) begin
                state          <= DONE;
                shift_q        <= 64'd0;
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
            end else begin
                state          <= RUN;
                shift_q        <= {32'd0, mag_a_in};
                data_resultRDY <= 1'b0;
                busy           <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!diff[32]) begin
                        shift_q <= {diff[31:0], shift_q[30:0], 1'b1};
                    end else begin
                        shift_q <= {shift_q[62:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative_core.sv
// tb_div_iterative_core
// Directed and randomized divides checked against an arithmetic
// reference model (magnitude quotient and remainder via / and %).

module tb_div_iterative_core;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [63:0] quotientAfterShiftFrom64;
    logic [31:0] opA_q;
    logic [31:0] opB_q;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    int n_cmp;
    int n_bad;

    div_iterative_core dut (
        .clock                    (clock),
        .reset                    (reset),
        .ctrl_DIV                 (ctrl_DIV),
        .data_operandA            (data_operandA),
        .data_operandB            (data_operandB),
        .quotientAfterShiftFrom64 (quotientAfterShiftFrom64),
        .opA_q                    (opA_q),
        .opB_q                    (opB_q),
        .data_resultRDY           (data_resultRDY),
        .data_exception           (data_exception),
        .busy                     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v);
        logic [31:0] m;
        m = v;
        if (v[31]) m = 32'(-v);
        return m;
    endfunction

    // Reference: {remainder magnitude, quotient magnitude}, zero for a zero divisor
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = mag(a);
        mb = mag(b);
        if (mb == 32'd0) return 64'd0;
        return {ma % mb, ma / mb};
    endfunction

    // Called at a negedge; the next rising edge accepts the start (E0)
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called at the negedge after E0; returns at the negedge where resultRDY is seen
    task automatic await_result(input logic [31:0] a, input logic [31:0] b);
        int n;
        int busy_err;
        int exp_lat;
        n        = 0;
        busy_err = 0;
        exp_lat  = (mag(b) == 32'd0) ? 0 : 32;
        while (!data_resultRDY && n < 40) begin
            if (busy !== (mag(b) != 32'd0)) busy_err++;
            @(negedge clock);
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("busy_during_run", 64'(busy_err), 64'd0);
        check("result", quotientAfterShiftFrom64, ref_div(a, b));
        check("exception", 64'(data_exception), 64'(mag(b) == 32'd0));
        check("opA_q", 64'(opA_q), 64'(a));
        check("opB_q", 64'(opB_q), 64'(b));
        check("busy_done", 64'(busy), 64'd0);
    endtask

    // One cycle past DONE: pulse gone, results held
    task automatic check_held(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        check("rdy_pulse_end", 64'(data_resultRDY), 64'd0);
        repeat (3) @(negedge clock);
        check("hold_result", quotientAfterShiftFrom64, ref_div(a, b));
        check("hold_opA", 64'(opA_q), 64'(a));
        check("hold_opB", 64'(opB_q), 64'(b));
        check("hold_exc", 64'(data_exception), 64'(mag(b) == 32'd0));
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic full_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        await_result(a, b);
        check_held(a, b);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {quotientAfterShiftFrom64, opA_q, opB_q}, 128'd0);
        check(tag, {61'd0, data_resultRDY, data_exception, busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          hits;
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;

        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_no_rdy", 64'(data_resultRDY), 64'd0);

        // Directed cases
        full_op(32'd100, 32'd7);
        check("dir_100_7", quotientAfterShiftFrom64, 64'h00000002_0000000E);
        full_op(32'hFFFFFF9C, 32'd7);
        check("dir_m100_7", quotientAfterShiftFrom64, 64'h00000002_0000000E);
        full_op(32'h80000000, 32'd1);
        check("dir_min_1", quotientAfterShiftFrom64, 64'h00000000_80000000);
        full_op(32'h80000000, 32'hFFFFFFFF);
        check("dir_min_m1", quotientAfterShiftFrom64[31:0], 64'h80000000);
        full_op(32'd55, 32'd0);
        check("dir_div0", quotientAfterShiftFrom64, 64'd0);
        full_op(32'd5, 32'h80000000);
        full_op(32'hFFFFFFFF, 32'hFFFFFFFF);

        // Restart: second start at E10 overrides the first
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        issue(32'd9, 32'd2);
        await_result(32'd9, 32'd2);
        check("restart_val", quotientAfterShiftFrom64, 64'h00000001_00000004);
        check_held(32'd9, 32'd2);

        // Start accepted in the DONE cycle, after resultRDY was observed
        issue(32'd20, 32'd3);
        await_result(32'd20, 32'd3);
        issue(32'hFFFFFFF9, 32'd2);
        await_result(32'hFFFFFFF9, 32'd2);
        check_held(32'hFFFFFFF9, 32'd2);

        // Reset in the middle of an operation (at E15)
        issue(32'd100, 32'd7);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check_all_zero("reset_mid_op");
        @(negedge clock);
        reset = 1'b0;
        hits  = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) hits++;
        end
        check("no_run_after_reset", 64'(hits), 64'd0);
        check_all_zero("after_reset_idle");
        full_op(32'd1000, 32'd33);

        // Randomized operands, with a bias toward corner values
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h80000000;
                3: b = 32'(-$urandom_range(1, 15));
                4: a = $urandom_range(0, 20);
                default: ;
            endcase
            full_op(a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
